id_ex_reg: RTL and testbench



---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pipe_reg.sv | 17 +
 rtl/id_ex_reg.sv | 85 ++++++++
 tb/tb_id_ex_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline widths and the ID/EX bundle types.
package cpu_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic               regdst;
    logic               jump;
    logic               branch;
    logic               memread;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
  } id_ex_ctrl_t;

  // Everything the execute stage consumes, registered as one bus.
  typedef struct packed {
    id_ex_ctrl_t       ctrl;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;
    logic [DATA_W-1:0] sign_ext;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
  } id_ex_bus_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit D register with synchronous active-high clear.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle capture of decode outputs, clear inserts a NOP bubble.
module id_ex_reg
  import cpu_pkg::*;
(
  input  logic               startin,
  input  logic               clk,
  input  logic               regdstIn,
  input  logic               jumpIn,
  input  logic               branchIn,
  input  logic               memreadIn,
  input  logic               memtoregIn,
  input  logic               memwriteIn,
  input  logic               alusrcIn,
  input  logic               regwriteIn,
  input  logic [ALUOP_W-1:0] aluopIn,
  input  logic [DATA_W-1:0]  read1In,
  input  logic [DATA_W-1:0]  read2In,
  input  logic [DATA_W-1:0]  signExtendedIn,
  input  logic [REG_W-1:0]   ins20_16In,
  input  logic [REG_W-1:0]   ins15_11In,
  input  logic [REG_W-1:0]   ins25_21In,
  output logic               regdst,
  output logic               jump,
  output logic               branch,
  output logic               memread,
  output logic               memtoreg,
  output logic               memwrite,
  output logic               alusrc,
  output logic               regwrite,
  output logic [ALUOP_W-1:0] aluop,
  output logic [DATA_W-1:0]  read1,
  output logic [DATA_W-1:0]  read2,
  output logic [DATA_W-1:0]  signExtended,
  output logic [REG_W-1:0]   ins20_16,
  output logic [REG_W-1:0]   ins15_11,
  output logic [REG_W-1:0]   ins25_21
);

  id_ex_bus_t d_bus;
  id_ex_bus_t q_bus;

  always_comb begin
    d_bus               = '0;
    d_bus.ctrl.regdst   = regdstIn;
    d_bus.ctrl.jump     = jumpIn;
    d_bus.ctrl.branch   = branchIn;
    d_bus.ctrl.memread  = memreadIn;
    d_bus.ctrl.memtoreg = memtoregIn;
    d_bus.ctrl.memwrite = memwriteIn;
    d_bus.ctrl.alusrc   = alusrcIn;
    d_bus.ctrl.regwrite = regwriteIn;
    d_bus.ctrl.aluop    = aluopIn;
    d_bus.read1         = read1In;
    d_bus.read2         = read2In;
    d_bus.sign_ext      = signExtendedIn;
    d_bus.rt            = ins20_16In;
    d_bus.rd            = ins15_11In;
    d_bus.rs            = ins25_21In;
  end

  // NOTE: startin is a synchronous clear; clearing every field (not just regwrite/memwrite) keeps the bubble fully deterministic.
  pipe_reg #(.W($bits(id_ex_bus_t))) u_bus_reg (
    .clk (clk),
    .rst (startin),
    .d   (d_bus),
    .q   (q_bus)
  );

  assign regdst       = q_bus.ctrl.regdst;
  assign jump         = q_bus.ctrl.jump;
  assign branch       = q_bus.ctrl.branch;
  assign memread      = q_bus.ctrl.memread;
  assign memtoreg     = q_bus.ctrl.memtoreg;
  assign memwrite     = q_bus.ctrl.memwrite;
  assign alusrc       = q_bus.ctrl.alusrc;
  assign regwrite     = q_bus.ctrl.regwrite;
  assign aluop        = q_bus.ctrl.aluop;
  assign read1        = q_bus.read1;
  assign read2        = q_bus.read2;
  assign signExtended = q_bus.sign_ext;
  assign ins20_16     = q_bus.rt;
  assign ins15_11     = q_bus.rd;
  assign ins25_21     = q_bus.rs;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed, table-driven bench for the ID/EX pipeline register.
module tb_id_ex_reg;

  typedef struct packed {
    logic [7:0]  ctrl;   // {regdst,jump,branch,memread,memtoreg,memwrite,alusrc,regwrite}
    logic [1:0]  aluop;
    logic [31:0] read1;
    logic [31:0] read2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  rs;
  } io_t;

  typedef struct {
    string name;
    logic  rst;
    io_t   stim;
    io_t   exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        startin;
  logic        regdstIn, jumpIn, branchIn, memreadIn, memtoregIn, memwriteIn, alusrcIn, regwriteIn;
  logic [1:0]  aluopIn;
  logic [31:0] read1In, read2In, signExtendedIn;
  logic [4:0]  ins20_16In, ins15_11In, ins25_21In;
  logic        regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [1:0]  aluop;
  logic [31:0] read1, read2, signExtended;
  logic [4:0]  ins20_16, ins15_11, ins25_21;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .startin(startin), .clk(clk),
    .regdstIn(regdstIn), .jumpIn(jumpIn), .branchIn(branchIn), .memreadIn(memreadIn),
    .memtoregIn(memtoregIn), .memwriteIn(memwriteIn), .alusrcIn(alusrcIn), .regwriteIn(regwriteIn),
    .aluopIn(aluopIn), .read1In(read1In), .read2In(read2In), .signExtendedIn(signExtendedIn),
    .ins20_16In(ins20_16In), .ins15_11In(ins15_11In), .ins25_21In(ins25_21In),
    .regdst(regdst), .jump(jump), .branch(branch), .memread(memread),
    .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite),
    .aluop(aluop), .read1(read1), .read2(read2), .signExtended(signExtended),
    .ins20_16(ins20_16), .ins15_11(ins15_11), .ins25_21(ins25_21)
  );

  function automatic io_t mk(input logic [7:0] c, input logic [1:0] op,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] se,
                             input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] rs);
    io_t v;
    v.ctrl = c; v.aluop = op; v.read1 = r1; v.read2 = r2; v.sext = se;
    v.rt = rt; v.rd = rd; v.rs = rs;
    return v;
  endfunction

  task automatic drive(input io_t v);
    {regdstIn, jumpIn, branchIn, memreadIn, memtoregIn, memwriteIn, alusrcIn, regwriteIn} = v.ctrl;
    aluopIn = v.aluop; read1In = v.read1; read2In = v.read2; signExtendedIn = v.sext;
    ins20_16In = v.rt; ins15_11In = v.rd; ins25_21In = v.rs;
  endtask

  function automatic io_t sample();
    io_t v;
    v.ctrl  = {regdst, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite};
    v.aluop = aluop; v.read1 = read1; v.read2 = read2; v.sext = signExtended;
    v.rt = ins20_16; v.rd = ins15_11; v.rs = ins25_21;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam io_t CAP   = '{ctrl: 8'b1010_1010, aluop: 2'd2, read1: 32'd8, read2: 32'd10,
                             sext: 32'd25, rt: 5'd4, rd: 5'd5, rs: 5'd6};
  localparam io_t INV   = '{ctrl: 8'b0101_0101, aluop: 2'd1, read1: 32'd8, read2: 32'd10,
                             sext: 32'd25, rt: 5'd4, rd: 5'd5, rs: 5'd6};
  localparam io_t BUSY  = '{ctrl: 8'b1111_1111, aluop: 2'd3, read1: 32'h1234_5678, read2: 32'hCAFE_0001,
                             sext: 32'hFFFF_FFF0, rt: 5'd17, rd: 5'd9, rs: 5'd30};
  localparam io_t WIDE  = '{ctrl: 8'b1111_1111, aluop: 2'd3, read1: 32'hFFFF_FFFF, read2: 32'hFFFF_FFFF,
                             sext: 32'hFFFF_FFFF, rt: 5'd31, rd: 5'd31, rs: 5'd31};
  localparam io_t ZERO  = '0;

  vec_t vecs[7];

  initial begin
    io_t got;

    vecs[0] = '{name: "reset",         rst: 1'b1, stim: BUSY, exp: ZERO};
    vecs[1] = '{name: "capture",       rst: 1'b0, stim: CAP,  exp: CAP};
    vecs[2] = '{name: "inverted_ctrl", rst: 1'b0, stim: INV,  exp: INV};
    vecs[3] = '{name: "reset_midrun",  rst: 1'b1, stim: BUSY, exp: ZERO};
    vecs[4] = '{name: "resume",        rst: 1'b0, stim: BUSY, exp: BUSY};
    vecs[5] = '{name: "width_max",     rst: 1'b0, stim: WIDE, exp: WIDE};
    vecs[6] = '{name: "all_zero",      rst: 1'b0, stim: ZERO, exp: ZERO};

    startin = 1'b1;
    drive(BUSY);

    // Inputs and startin change on the falling edge; outputs are read 1 ns after the rising edge.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      startin = vecs[i].rst;
      drive(vecs[i].stim);
      @(posedge clk);
      #1;
      got = sample();
      check(vecs[i].name, 128'(got), 128'(vecs[i].exp));
      if (vecs[i].rst) begin
        check({vecs[i].name, "_regwrite"}, 128'(regwrite), 128'(0));
        check({vecs[i].name, "_memwrite"}, 128'(memwrite), 128'(0));
      end
      // Just before the next edge the outputs must not have moved.
      @(negedge clk);
      #4;
      got = sample();
      check({vecs[i].name, "_hold"}, 128'(got), 128'(vecs[i].exp));
    end

    // Latency/hold: mid-cycle change of read1In is ignored until the next edge.
    @(negedge clk);
    startin = 1'b0;
    drive(CAP);
    @(posedge clk);
    #1;
    check("hold_r1_initial", 128'(read1), 128'(32'd8));
    read1In = 32'd99;
    #3;
    check("hold_r1_midcycle", 128'(read1), 128'(32'd8));
    @(negedge clk);
    check("hold_r1_negedge", 128'(read1), 128'(32'd8));
    @(posedge clk);
    #1;
    check("hold_r1_next_edge", 128'(read1), 128'(32'd99));

    // A startin pulse that ends before the edge must not clear anything.
    @(negedge clk);
    drive(BUSY);
    startin = 1'b1;
    #2;
    startin = 1'b0;
    @(posedge clk);
    #1;
    got = sample();
    check("startin_between_edges", 128'(got), 128'(BUSY));

    // Reset for exactly one edge, then capture resumes on the following edge.
    @(negedge clk);
    startin = 1'b1;
    drive(WIDE);
    @(posedge clk);
    #1;
    got = sample();
    check("one_edge_reset", 128'(got), 128'(ZERO));
    @(negedge clk);
    startin = 1'b0;
    @(posedge clk);
    #1;
    got = sample();
    check("after_one_edge_reset", 128'(got), 128'(WIDE));
    check("wide_rs_31", 128'(ins25_21), 128'(5'd31));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
